// File: rtl/trigger_detector.sv
// trigger_detector: acquisition sequencer for a circular sample buffer with rising-crossing trigger.
// Tracks pre-trigger fill, armed search and post-trigger capture, and drives the RAM write port.
module trigger_detector #(
   parameter int BITS_ADC   = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  force_trigger,
   input  logic [ADDR_WIDTH-1:0] pretrigger,
   input  logic [BITS_ADC-1:0]   trigger_value_in,
   input  logic [BITS_ADC-1:0]   trigger_source_in,
   input  logic                  trigger_source_rdy,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [BITS_ADC-1:0]   wr_data,
   output logic                  triggered,
   output logic [ADDR_WIDTH-1:0] trigger_addr,
   output logic                  done,
   output logic                  busy
);
   typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, pre_q, pre_d, cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, taddr_q, taddr_d;
   logic [BITS_ADC-1:0]   prev_q, prev_d, wr_data_q, wr_data_d;
   logic                  prev_v_q, prev_v_d, force_q, force_d, wr_en_q, wr_en_d;
   logic                  trig_q, trig_d, done_q, done_d, busy_q, busy_d;
   logic                  act, go, acc, f, hit;
   assign act = state_q inside {PRE, ARMED, POST};
   assign go  = start & ~stop & ~act;
   assign acc = trigger_source_rdy & act & ~stop;
   assign f   = force_q | force_trigger;
   assign hit = acc & (state_q == ARMED) & (f | (prev_v_q & (prev_q < trigger_value_in) &
                (trigger_source_in >= trigger_value_in)));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         pre_q     <= '0;
         cnt_q     <= '0;
         wr_addr_q <= '0;
         taddr_q   <= '0;
         prev_q    <= '0;
         wr_data_q <= '0;
         prev_v_q  <= 1'b0;
         force_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         trig_q    <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         pre_q     <= pre_d;
         cnt_q     <= cnt_d;
         wr_addr_q <= wr_addr_d;
         taddr_q   <= taddr_d;
         prev_q    <= prev_d;
         wr_data_q <= wr_data_d;
         prev_v_q  <= prev_v_d;
         force_q   <= force_d;
         wr_en_q   <= wr_en_d;
         trig_q    <= trig_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end
   // pretrigger is ADDR_WIDTH wide, so it can never exceed DEPTH-1; ~pre_q is the post-trigger length
   always_comb begin
      state_d = state_q;
      if (stop) state_d = IDLE;
      else if (go) state_d = (pretrigger != '0) ? PRE : ARMED;
      else if (acc && state_q == PRE && (cnt_q + ADDR_WIDTH'(1)) == pre_q) state_d = ARMED;
      else if (hit) state_d = (pre_q == '1) ? DONE : POST;
      else if (acc && state_q == POST && (cnt_q + ADDR_WIDTH'(1)) == ~pre_q) state_d = DONE;
   end
   always_comb begin
      pre_d     = go ? pretrigger : pre_q;
      cnt_d     = (go || state_d != state_q) ? '0 : cnt_q + ADDR_WIDTH'(acc);
      ptr_d     = (go || stop) ? '0 : ptr_q + ADDR_WIDTH'(acc);
      wr_addr_d = (go || stop) ? '0 : ptr_q;
      wr_en_d   = acc;
      wr_data_d = acc ? trigger_source_in : wr_data_q;
      prev_d    = acc ? trigger_source_in : prev_q;
      prev_v_d  = go ? 1'b0 : prev_v_q | acc;
      force_d   = (go || stop || !(state_q inside {PRE, ARMED})) ? 1'b0 : f & ~hit;
      trig_d    = (go || stop) ? 1'b0 : trig_q | hit;
      taddr_d   = (go || stop) ? '0 : hit ? ptr_q : taddr_q;
      done_d    = (go || stop) ? 1'b0 : done_q | (state_q == DONE);
      busy_d    = state_d inside {PRE, ARMED, POST};
   end
   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign triggered    = trig_q;
   assign trigger_addr = taddr_q;
   assign done         = done_q;
   assign busy         = busy_q;
endmodule
